// File: rtl/elm_neuron_if.sv
// Stream-in / weight-read / result-out signal bundle for one ELM hidden neuron.
// The neuron owns the slave side; the memory and stream source sit on the master side.
interface elm_neuron_if #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic signed [dataWidth-1:0] myinput;
    logic                        myinputValid;
    logic signed [dataWidth-1:0] bias;
    logic                        wRen;
    logic        [addressWidth:0] wAddr;
    logic signed [dataWidth-1:0] wIn;
    logic signed [dataWidth-1:0] out;
    logic                        outvalid;

    modport slave (
        input  myinput, myinputValid, bias, wIn,
        output wRen, wAddr, out, outvalid
    );

    modport master (
        output myinput, myinputValid, bias, wIn,
        input  wRen, wAddr, out, outvalid
    );
endinterface

// File: rtl/elm_neuron.sv
// ELM hidden-layer neuron: streams activations against a registered weight memory,
// accumulates saturating fixed-point products, then adds bias and applies ReLU.
module elm_neuron #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracWidth    = 14
) (
    input  logic          clk,
    input  logic          rst,
    elm_neuron_if.slave   bus
);
    localparam int AW = addressWidth + 1;
    localparam int DW = dataWidth;
    localparam int PW = 2 * dataWidth;
    localparam logic [AW-1:0] LAST_ADDR = AW'(numWeight - 1);
    localparam logic signed [PW-1:0] MAX_W = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_W = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
        logic signed [DW-1:0] r;
        if (v > MAX_W)
            r = MAX_W[DW-1:0];
        else if (v < MIN_W)
            r = MIN_W[DW-1:0];
        else
            r = v[DW-1:0];
        return r;
    endfunction

    logic [AW-1:0] r_addr;
    logic          beat_first;
    logic          beat_last;

    assign bus.wRen   = bus.myinputValid & ~rst;
    assign bus.wAddr  = r_addr;
    assign beat_first = (r_addr == '0);
    assign beat_last  = (r_addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_addr <= '0;
        else if (bus.myinputValid)
            r_addr <= beat_last ? '0 : r_addr + AW'(1);
    end

    // Stage 1: delay the activation one cycle so it lines up with the memory read data.
    logic signed [DW-1:0] in_d;
    logic                 v1, f1, l1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_d <= '0;
            v1   <= 1'b0;
            f1   <= 1'b0;
            l1   <= 1'b0;
        end else begin
            in_d <= bus.myinput;
            v1   <= bus.myinputValid;
            f1   <= bus.myinputValid & beat_first;
            l1   <= bus.myinputValid & beat_last;
        end
    end

    // Stage 2: full-precision product, rescaled back to the word format.
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_shift;
    logic signed [DW-1:0] mul;
    logic                 v2, f2, l2;

    assign prod       = PW'(bus.wIn) * PW'(in_d);
    assign prod_shift = prod >>> fracWidth;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul <= '0;
            v2  <= 1'b0;
            f2  <= 1'b0;
            l2  <= 1'b0;
        end else begin
            mul <= sat(prod_shift);
            v2  <= v1;
            f2  <= f1;
            l2  <= l1;
        end
    end

    // Stage 3: a first-flagged beat reloads, so a new vector never sees the previous sum.
    logic signed [DW-1:0] acc;
    logic signed [PW-1:0] acc_sum;
    logic                 sum_valid;

    assign acc_sum = PW'(acc) + PW'(mul);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sum_valid <= 1'b0;
        end else begin
            if (v2)
                acc <= f2 ? mul : sat(acc_sum);
            sum_valid <= v2 & l2;
        end
    end

    // Stage 4: reads acc in the same cycle a back-to-back vector may reload it.
    logic signed [PW-1:0] bias_sum;
    logic signed [DW-1:0] biased;

    assign bias_sum = PW'(acc) + PW'(bus.bias);
    assign biased   = sat(bias_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out      <= '0;
            bus.outvalid <= 1'b0;
        end else begin
            bus.outvalid <= sum_valid;
            if (sum_valid)
                bus.out <= biased[DW-1] ? '0 : biased;
        end
    end
endmodule

// File: tb/tb_elm_neuron.sv
// Self-checking bench for elm_neuron (numWeight=4) with an integer reference model
// and a 1-cycle registered weight memory.
module tb_elm_neuron;
    localparam int NW = 4;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int FW = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elm_neuron_if #(.addressWidth(AW), .dataWidth(DW)) bus ();

    elm_neuron #(
        .numWeight(NW), .addressWidth(AW), .dataWidth(DW), .fracWidth(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic signed [DW-1:0] wmem [NW];
    always @(posedge clk)
        if (bus.wRen) bus.wIn <= wmem[int'(bus.wAddr) % NW];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int fx_mul(input int a, input int b);
        int p;
        p = a * b;
        return clamp(p >>> FW);
    endfunction

    // reference model state
    int m_idx = 0;
    int m_acc = 0;
    int exp_out = 0;
    int due_q[$];
    int val_q[$];
    int pv_q[$];
    int pc_q[$];
    int last_beat_cyc = 0;

    always @(negedge clk) begin
        int p;
        int t;
        bit exp_v;
        if (rst) begin
            chk("rst_out", int'(bus.out), 0);
            chk("rst_outvalid", int'(bus.outvalid), 0);
            chk("rst_wRen", int'(bus.wRen), 0);
            chk("rst_wAddr", int'(bus.wAddr), 0);
            m_idx = 0;
            m_acc = 0;
            exp_out = 0;
            due_q.delete();
            val_q.delete();
        end else begin
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            if (exp_v) begin
                exp_out = val_q[0];
                void'(due_q.pop_front());
                void'(val_q.pop_front());
            end
            chk("outvalid", int'(bus.outvalid), int'(exp_v));
            chk("out", int'(bus.out), exp_out);
            chk("wRen", int'(bus.wRen), int'(bus.myinputValid));
            chk("wAddr", int'(bus.wAddr), m_idx);
            if (bus.outvalid) begin
                pv_q.push_back(int'(bus.out));
                pc_q.push_back(cyc);
            end
            if (bus.myinputValid) begin
                p = fx_mul(int'(bus.myinput), int'(wmem[m_idx]));
                m_acc = (m_idx == 0) ? p : clamp(m_acc + p);
                if (m_idx == NW - 1) begin
                    t = clamp(m_acc + int'(bus.bias));
                    due_q.push_back(cyc + 4);
                    val_q.push_back(t < 0 ? 0 : t);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic beat(input int x);
        @(posedge clk); #1;
        bus.myinput      = x[15:0];
        bus.myinputValid = 1'b1;
        last_beat_cyc    = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.myinputValid = 1'b0;
        end
    endtask

    task automatic vec(input int x, input int gap, input bit addr_pin);
        for (int i = 0; i < NW; i++) begin
            beat(x);
            if (addr_pin) chk("wAddr_seq", int'(bus.wAddr), i);
            if (i < NW - 1 && gap > 0) idle(gap);
        end
    endtask

    task automatic set_w(input int w);
        for (int i = 0; i < NW; i++) wmem[i] = w[15:0];
    endtask

    task automatic reset_pulse(input bit keep_valid);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.myinputValid = keep_valid;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.myinputValid = 1'b0;
    endtask

    task automatic expect_one(input string name, input int v);
        chk({name, "_pulses"}, pv_q.size(), 1);
        if (pv_q.size() > 0) chk({name, "_val"}, pv_q[0], v);
        pv_q.delete();
        pc_q.delete();
    endtask

    initial begin
        int x;
        int g;
        rst = 1'b1;
        bus.myinput = '0;
        bus.myinputValid = 1'b0;
        bus.bias = '0;
        set_w(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // basic
        set_w(16'h1000);
        bus.bias = 16'h1000;
        pv_q.delete(); pc_q.delete();
        vec(16'h4000, 0, 1'b1);
        x = last_beat_cyc;
        idle(8);
        if (pc_q.size() > 0) chk("basic_latency", pc_q[0] - x, 4);
        expect_one("basic", 16'h5000);

        // saturation
        set_w(16'h2000);
        bus.bias = 16'h0000;
        vec(16'h4000, 0, 1'b0);
        idle(8);
        expect_one("sat", 16'h7FFF);

        // relu
        set_w(16'hF000);
        vec(16'h4000, 0, 1'b0);
        idle(8);
        expect_one("relu", 16'h0000);

        // gaps then back-to-back
        set_w(16'h1000);
        vec(16'h4000, 2, 1'b0);
        vec(16'h2000, 0, 1'b0);
        idle(8);
        chk("b2b_pulses", pv_q.size(), 2);
        if (pv_q.size() == 2) begin
            chk("b2b_val_a", pv_q[0], 16'h4000);
            chk("b2b_val_b", pv_q[1], 16'h2000);
            chk("b2b_spacing", pc_q[1] - pc_q[0], 4);
        end
        pv_q.delete(); pc_q.delete();

        // reset mid-vector
        bus.bias = 16'h1000;
        beat(16'h4000);
        beat(16'h4000);
        reset_pulse(1'b1);
        chk("post_rst_out", int'(bus.out), 0);
        vec(16'h4000, 0, 1'b1);
        idle(8);
        expect_one("rst_mid", 16'h5000);

        // randomized groups: parameters change only while the pipeline is empty
        for (int grp = 0; grp < 12; grp++) begin
            for (int i = 0; i < NW; i++)
                wmem[i] = (grp % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3000) - 16'h1800);
            x = int'($urandom_range(0, 16'h8000)) - 16'h4000;
            bus.bias = x[15:0];
            for (int v = 0; v < 3; v++) begin
                for (int i = 0; i < NW; i++) begin
                    if (grp % 3 == 0)
                        x = int'($urandom_range(0, 65535)) - 32768;
                    else
                        x = int'($urandom_range(0, 16'h8000)) - 16'h4000;
                    beat(x);
                    g = int'($urandom_range(0, 3));
                    if (g == 3) g = 0;
                    if (g > 0) idle(g);
                    if ($urandom_range(0, 30) == 0) reset_pulse(1'($urandom_range(0, 1)));
                end
            end
            idle(8);
        end
        chk("queue_drained", due_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elm_neuron.md
# elm_neuron

Hidden-layer neuron datapath for the ELM accelerator. It consumes a serial stream of input activations and drives the read port (`ren`/`raddr`) of its per-neuron weight memory. It multiplies each activation by the weight returned one cycle later and accumulates the products in saturating fixed point. After `numWeight` beats it adds the bias, applies ReLU and emits one output word with a one-cycle valid pulse.

## Interface
Parameters:
- `numWeight`, 784, number of input beats (weights) per evaluation; must be ≤ 2**addressWidth.
- `addressWidth`, 10, weight memory address width; the address port is `addressWidth+1` bits, matching the weight memory.
- `dataWidth`, 16, width of input, weight, bias and output words (signed two's complement).
- `fracWidth`, 14, fractional bits of every word (default Q2.14).

Ports:
- `clk`  in  1  clock; all registers on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `myinput`  in  dataWidth  input activation, signed.
- `myinputValid`  in  1  `myinput` valid this cycle; one beat per cycle; no backpressure.
- `bias`  in  dataWidth  signed bias; held static while the block is running.
- `wRen`  out  1  weight memory read enable; connects to memory `ren`.
- `wAddr`  out  addressWidth+1  weight read address; connects to memory `raddr`.
- `wIn`  in  dataWidth  weight read data; registered memory output, valid 1 cycle after `wRen`.
- `out`  out  dataWidth  neuron result (ReLU output), signed, never negative.
- `outvalid`  out  1  one-cycle pulse when `out` is updated.

## Operation
- **Address counter `rAddr`** (addressWidth+1 bits):
  - `wAddr = rAddr`; `wRen = myinputValid & ~rst` (combinational).
  - On each valid beat, `rAddr` increments.
  - After beat `numWeight-1`, `rAddr` wraps to 0.
- **Beat flags:** every beat carries a `first` flag (`rAddr==0`) and a `last` flag (`rAddr==numWeight-1`). Both are pipelined alongside the data.
- **Stage 1** (cycle after the beat): register `myinput`, `valid`, `first` and `last`, so the input aligns with `wIn`.
- **Stage 2:**
  - Signed product `wIn*myinput_d`, 2·dataWidth bits.
  - Arithmetic shift right by `fracWidth`.
  - Saturate to dataWidth: values above max become 0x7FFF; values below min become 0x8000 (defaults).
  - Register the result as `mul`, with its flags.
- **Stage 3 (accumulator `acc`):**
  - If `mul` is valid and `first`: `acc <= mul` (load; discards the previous vector).
  - If `mul` is valid and not `first`: `acc <= sat(acc+mul)`, with the sum computed at dataWidth+1 bits and then saturated.
  - `last` sets `sumValid` for exactly one cycle.
- **Stage 4:** when `sumValid` is high:
  - `t = sat(acc+bias)`.
  - `out <= (t<0) ? 0 : t`.
  - `outvalid <= 1`.
  - Otherwise `outvalid <= 0` and `out` holds its value.
- **Reset values:** `rAddr`=0; all pipeline valid/flag registers 0; `acc`=0; `out`=0; `outvalid`=0.
- **Reset mid-vector:** the partial sum is discarded, no `outvalid` is produced for it, and the next beat after reset is treated as beat 0.
- **Idle gaps:** gaps between beats are allowed anywhere in a vector; `acc` and flags hold.
- **Back-to-back vectors:** beat 0 of vector N+1 may arrive the cycle after the last beat of vector N. The stage-3 load and the stage-4 read of `acc` occur in the same cycle. Stage 4 samples the old `acc`, so both results are correct.
- `numWeight`=1 is legal: `first` and `last` are both set on every beat.

## Timing
- Beat k presented in cycle t: `wRen`=1 and `wAddr`=k in cycle t.
- `wIn` for that beat is valid in t+1.
- `mul` for that beat is valid in t+2; `acc` reflects it in t+3.
- Last beat in cycle t: `outvalid`=1 and `out` valid in cycle t+4.
- Latency is fixed at 4 cycles after the last beat; throughput is 1 beat/cycle.
- Minimum spacing between `outvalid` pulses is `numWeight` cycles.
- `rst` asserted at any edge clears all state immediately (asynchronous), including a pending `outvalid`.

## Test plan
All scenarios use `numWeight`=4 and defaults otherwise (1.0 = 0x4000); the bench models a 1-cycle registered weight memory.
- **Basic:** 4 consecutive beats of input 0x4000, weights 0x1000, bias 0x1000 -> `wAddr` 0,1,2,3; `outvalid` 4 cycles after beat 3; `out`=0x5000.
- **Saturation:** inputs 0x4000, weights 0x2000, bias 0 -> accumulator saturates; `out`=0x7FFF.
- **ReLU:** inputs 0x4000, weights 0xF000 (-0.25), bias 0 -> sum -1.0; `out`=0x0000 with `outvalid` pulse.
- **Gaps and back-to-back:**
  - Vector A (weights 0x1000, inputs 0x4000, bias 0) with 2 idle cycles between beats -> 0x4000.
  - Vector B follows immediately with no gap (inputs 0x2000) -> 0x2000.
  - Two separate one-cycle `outvalid` pulses, 4 cycles apart.
- **Reset mid-vector:** 2 beats, assert `rst` for one cycle, then a full 4-beat basic vector -> no pulse for the partial vector; `wAddr` restarts at 0; `out`=0x5000.
- **Reset values:** during and immediately after `rst` -> `out`=0, `outvalid`=0, `wRen`=0.
